// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with valid/ready handshake and iterative MUL/DIV; macro SEQ_ALU_SAT_EN saturates ADD/SUB
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic [WIDTH-1:0] hi,
   output logic             carry,
   output logic             zero,
   output logic             dbz
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_b;
   // r_phi/r_plo: product halves during MUL, remainder/quotient during DIV
   logic [WIDTH-1:0] r_phi;
   logic [WIDTH-1:0] r_plo;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_f;
   logic [WIDTH-1:0] r_hi;
   logic             r_carry;
   logic             r_zero;
   logic             r_dbz;
   logic             r_out_valid;

   logic [WIDTH:0]   w_sum;
   logic             w_borrow;
   logic [WIDTH-1:0] w_f;
   logic [WIDTH-1:0] w_hi;
   logic             w_carry;
   logic             w_dbz;
   logic             w_iter;
   logic             w_last;
   logic [WIDTH:0]   w_madd;
   logic [WIDTH-1:0] w_mhi;
   logic [WIDTH-1:0] w_mlo;
   logic [WIDTH:0]   w_dshift;
   logic             w_dge;
   logic [WIDTH-1:0] w_drem;
   logic [WIDTH-1:0] w_dquo;

   assign in_ready  = rst_n && (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign f         = r_f;
   assign hi        = r_hi;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign dbz       = r_dbz;

   assign w_sum    = {1'b0, a} + {1'b0, b};
   assign w_borrow = (a < b);
   // MUL always iterates; DIV iterates only when the divisor is nonzero
   assign w_iter   = mode && op[1] && (op[0] || (b != '0));
   assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

   // One shift-add step: add multiplicand if multiplier LSB set, then shift the pair right
   assign w_madd = {1'b0, r_phi} + (r_plo[0] ? {1'b0, r_b} : '0);
   assign w_mhi  = w_madd[WIDTH:1];
   assign w_mlo  = {w_madd[0], r_plo[WIDTH-1:1]};

   // One restoring-division step: bring in next dividend bit, subtract divisor if it fits
   assign w_dshift = {r_phi, r_plo[WIDTH-1]};
   assign w_dge    = (w_dshift >= {1'b0, r_b});
   assign w_drem   = WIDTH'(w_dge ? (w_dshift - {1'b0, r_b}) : w_dshift);
   assign w_dquo   = {r_plo[WIDTH-2:0], w_dge};

   // Single-cycle results computed directly from the command inputs at acceptance
   always_comb begin
      w_f     = '0;
      w_hi    = '0;
      w_carry = 1'b0;
      w_dbz   = 1'b0;
      if (mode) begin
         case (op)
            2'b00: begin
               w_f     = w_sum[WIDTH-1:0];
               w_carry = w_sum[WIDTH];
`ifdef SEQ_ALU_SAT_EN
               if (w_sum[WIDTH]) w_f = '1;
`endif
            end
            2'b01: begin
               w_f     = a - b;
               w_carry = w_borrow;
`ifdef SEQ_ALU_SAT_EN
               if (w_borrow) w_f = '0;
`endif
            end
            2'b10: begin
               w_f   = '1;
               w_hi  = a;
               w_dbz = 1'b1;
            end
            default: w_f = '0;
         endcase
      end else begin
         case (op)
            2'b00:   w_f = a & b;
            2'b01:   w_f = a | b;
            2'b10:   w_f = a ^ b;
            default: w_f = ~a;
         endcase
      end
   end

   // Control FSM, iteration datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_b         <= '0;
         r_phi       <= '0;
         r_plo       <= '0;
         r_cnt       <= '0;
         r_f         <= '0;
         r_hi        <= '0;
         r_carry     <= 1'b0;
         r_zero      <= 1'b0;
         r_dbz       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_b   <= b;
                  r_cnt <= '0;
                  if (w_iter) begin
                     r_phi   <= '0;
                     r_plo   <= a;
                     r_state <= op[0] ? S_MUL : S_DIV;
                  end else begin
                     r_f         <= w_f;
                     r_hi        <= w_hi;
                     r_carry     <= w_carry;
                     r_zero      <= (w_f == '0);
                     r_dbz       <= w_dbz;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               r_phi <= w_mhi;
               r_plo <= w_mlo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_f         <= w_mlo;
                  r_hi        <= w_mhi;
                  r_carry     <= 1'b0;
                  r_zero      <= (w_mlo == '0);
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DIV: begin
               r_phi <= w_drem;
               r_plo <= w_dquo;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_f         <= w_dquo;
                  r_hi        <= w_drem;
                  r_carry     <= 1'b0;
                  r_zero      <= (w_dquo == '0);
                  r_dbz       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            default: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard bench for seq_alu with randomized commands and back-pressure
module tb_seq_alu;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         mode = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] f;
   logic [W-1:0] hi;
   logic         carry;
   logic         zero;
   logic         dbz;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .op(op), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .f(f), .hi(hi), .carry(carry), .zero(zero), .dbz(dbz)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] f;
      logic [W-1:0] hi;
      logic         carry;
      logic         zero;
      logic         dbz;
      int           rise;
      string        name;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   bit   rand_bp = 0;
   bit   prev_v = 0;
   exp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic string opname(input logic m, input logic [1:0] o);
      case ({m, o})
         3'b100:  return "add";
         3'b101:  return "sub";
         3'b110:  return "div";
         3'b111:  return "mul";
         3'b000:  return "and";
         3'b001:  return "or";
         3'b010:  return "xor";
         default: return "not";
      endcase
   endfunction

   // Reference behaviour from plain integer arithmetic
   function automatic exp_t model(input logic m, input logic [1:0] o,
                                  input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t r;
      longint unsigned ua = x;
      longint unsigned ub = y;
      longint unsigned md = 64'd1 << W;
      longint unsigned t;
      r.hi = '0; r.carry = 0; r.dbz = 0; r.f = '0; r.rise = 0;
      r.name = opname(m, o);
      if (m) begin
         case (o)
            2'd0: begin
               t = ua + ub;
               r.f = W'(t % md);
               r.carry = (t >= md);
`ifdef SEQ_ALU_SAT_EN
               if (r.carry) r.f = W'(md - 1);
`endif
            end
            2'd1: begin
               r.carry = (ua < ub);
               r.f = W'((ua + md - ub) % md);
`ifdef SEQ_ALU_SAT_EN
               if (r.carry) r.f = '0;
`endif
            end
            2'd2: begin
               if (ub == 0) begin
                  r.f = W'(md - 1); r.hi = x; r.dbz = 1;
               end else begin
                  r.f = W'(ua / ub); r.hi = W'(ua % ub);
               end
            end
            default: begin
               t = ua * ub;
               r.f = W'(t % md); r.hi = W'(t / md);
            end
         endcase
      end else begin
         case (o)
            2'd0:    r.f = x & y;
            2'd1:    r.f = x | y;
            2'd2:    r.f = x ^ y;
            default: r.f = ~x;
         endcase
      end
      r.zero = (r.f == '0);
      return r;
   endfunction

   // Drive a command from a negedge; returns at the negedge after acceptance
   task automatic issue(input logic m, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit push);
      exp_t e;
      int   waitc = 0;
      mode = m; op = o; a = x; b = y; in_valid = 1'b1;
      while (!in_ready && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      e = model(m, o, x, y);
      e.rise = cyc + 1 + ((m && o == 2'd3) || (m && o == 2'd2 && y != '0) ? W : 0);
      if (push) sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 out_ready = v;
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("drain_timeout", 0, 1);
   endtask

   always @(posedge clk) begin
      if (rand_bp) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares every presented result against the scoreboard head
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v = 0;
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               mon_e = sb[0];
               if (!prev_v) chk({mon_e.name, ".rise_cycle"}, cyc, mon_e.rise);
               chk({mon_e.name, ".f"}, f, mon_e.f);
               chk({mon_e.name, ".hi"}, hi, mon_e.hi);
               chk({mon_e.name, ".carry"}, carry, mon_e.carry);
               chk({mon_e.name, ".zero"}, zero, mon_e.zero);
               chk({mon_e.name, ".dbz"}, dbz, mon_e.dbz);
               chk({mon_e.name, ".in_ready_busy"}, in_ready, 0);
               if (out_ready) void'(sb.pop_front());
            end
         end
         prev_v = out_valid;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      logic         rm;
      logic [1:0]   ro;
      logic [W-1:0] rx;
      logic [W-1:0] ry;

      repeat (2) @(negedge clk);
      chk("reset.in_ready", in_ready, 0);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.f", f, 0);
      chk("reset.hi", hi, 0);
      chk("reset.flags", {carry, zero, dbz}, 0);
      rst_n = 1'b1;
      set_ready(1'b1);

      issue(1, 2'd0, 8'd200, 8'd100, 1);
      drain();

      issue(1, 2'd3, 8'd255, 8'd255, 1);
      n = 0;
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("mul.busy_cycles", n, W + 1);
      issue(1, 2'd3, 8'd0, 8'd77, 1);
      issue(1, 2'd2, 8'd100, 8'd7, 1);
      issue(1, 2'd2, 8'd5, 8'd0, 1);
      issue(0, 2'd0, 8'hC3, 8'h5A, 1);
      issue(0, 2'd1, 8'hC3, 8'h5A, 1);
      issue(0, 2'd2, 8'hC3, 8'h5A, 1);
      issue(0, 2'd3, 8'hC3, 8'h5A, 1);
      drain();

      set_ready(1'b0);
      issue(1, 2'd1, 8'd3, 8'd5, 1);
      repeat (5) @(negedge clk);
      set_ready(1'b1);
      @(negedge clk);
      chk("bp.out_valid_after", out_valid, 0);
      chk("bp.in_ready_after", in_ready, 1);
      drain();

      issue(1, 2'd3, 8'd255, 8'd255, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", out_valid, 0);
      chk("midrst.in_ready", in_ready, 0);
      chk("midrst.f", f, 0);
      chk("midrst.hi", hi, 0);
      chk("midrst.flags", {carry, zero, dbz}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst.in_ready", in_ready, 1);
      chk("postrst.out_valid", out_valid, 0);
      @(negedge clk);
      issue(1, 2'd0, 8'd1, 8'd1, 1);
      drain();

      rand_bp = 1;
      for (int i = 0; i < 60; i++) begin
         rm = 1'($urandom_range(0, 1));
         ro = 2'($urandom_range(0, 3));
         rx = W'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         issue(rm, ro, rx, ry, 1);
      end
      drain();
      rand_bp = 0;
      set_ready(1'b1);
      chk("final.scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
